// File: rtl/approx_sweep_pkg.sv
// Shared widths, FSM state encoding and the S1 pipeline record for the
// approximate-multiplier error sweep.
package approx_sweep_pkg;

  localparam int unsigned OPW  = 8;
  localparam int unsigned PW   = 16;
  localparam int unsigned CNTW = 17;
  localparam int unsigned SUMW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] x;
    logic [PW-1:0]  approx;
    logic [PW-1:0]  exact;
    logic           valid;
  } s1_t;

endpackage

// File: rtl/approx_mult_sweep_ctrl_err_accum.sv
// S2 of the sweep pipeline: error counters, absolute/signed error sums and
// first-occurrence worst-case tracking. SIGNED_BIAS_EN adds the signed sum.
module err_accum
  import approx_sweep_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [OPW-1:0]  a_i,
  input  logic [OPW-1:0]  x_i,
  input  logic [PW-1:0]   approx_i,
  input  logic [PW-1:0]   exact_i,
  output logic [CNTW-1:0] correct_cnt_o,
  output logic [CNTW-1:0] err_cnt_o,
  output logic [SUMW-1:0] sum_abs_err_o,
  output logic [PW-1:0]   max_abs_err_o,
  output logic [OPW-1:0]  max_err_a_o,
  output logic [OPW-1:0]  max_err_x_o
`ifdef SIGNED_BIAS_EN
  ,
  output logic [SUMW:0]   sum_signed_err_o
`endif
);

  logic [CNTW-1:0] correct_q, err_q;
  logic [SUMW-1:0] sum_q;
  logic [PW-1:0]   max_q;
  logic [OPW-1:0]  max_a_q, max_x_q;
  logic [PW:0]     diff, abs_full;
  logic [PW-1:0]   abs_err;

  // Exact minus approx at 17 bits; magnitude always fits in 16.
  assign diff     = {1'b0, exact_i} - {1'b0, approx_i};
  assign abs_full = diff[PW] ? ({(PW+1){1'b0}} - diff) : diff;
  assign abs_err  = abs_full[PW-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      correct_q <= '0;
      err_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      max_a_q   <= '0;
      max_x_q   <= '0;
    end else if (clear_i) begin
      correct_q <= '0;
      err_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      max_a_q   <= '0;
      max_x_q   <= '0;
    end else if (en_i) begin
      if (approx_i == exact_i) begin
        correct_q <= correct_q + CNTW'(1);
      end else begin
        err_q <= err_q + CNTW'(1);
      end
      sum_q <= sum_q + {{(SUMW-PW){1'b0}}, abs_err};
      // Strictly greater keeps the earliest pair on ties.
      if (abs_err > max_q) begin
        max_q   <= abs_err;
        max_a_q <= a_i;
        max_x_q <= x_i;
      end
    end
  end

`ifdef SIGNED_BIAS_EN
  logic [SUMW:0] ssum_q;
  logic [PW:0]   sdiff;

  assign sdiff = {1'b0, approx_i} - {1'b0, exact_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ssum_q <= '0;
    end else if (clear_i) begin
      ssum_q <= '0;
    end else if (en_i) begin
      ssum_q <= ssum_q + {{(SUMW-PW){sdiff[PW]}}, sdiff};
    end
  end

  assign sum_signed_err_o = ssum_q;
`endif

  assign correct_cnt_o = correct_q;
  assign err_cnt_o     = err_q;
  assign sum_abs_err_o = sum_q;
  assign max_abs_err_o = max_q;
  assign max_err_a_o   = max_a_q;
  assign max_err_x_o   = max_x_q;

endmodule

// File: rtl/multiplier_8x8.sv
// Behavioural stand-in for the 8x8 approximate multiplier under test:
// a truncating multiplier whose low four product bits are forced to zero.
module multiplier_8x8 (
  input  logic [7:0]  A,
  input  logic [7:0]  X,
  output logic [15:0] product
);

  logic [15:0] full;

  assign full    = {8'd0, A} * {8'd0, X};
  assign product = full & 16'hFFF0;

endmodule

// File: rtl/approx_mult_sweep_ctrl.sv
// Sweep controller: walks flat index {A,X} through multiplier_8x8 in a
// three-stage pipeline and accumulates error statistics. SIGNED_BIAS_EN adds sum_signed_err.
module approx_mult_sweep_ctrl
  import approx_sweep_pkg::*;
#(
  parameter logic [15:0] SWEEP_LAST = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] correct_cnt,
  output logic [CNTW-1:0] err_cnt,
  output logic [SUMW-1:0] sum_abs_err,
  output logic [PW-1:0]   max_abs_err,
  output logic [OPW-1:0]  max_err_a,
  output logic [OPW-1:0]  max_err_x
`ifdef SIGNED_BIAS_EN
  ,
  output logic [SUMW:0]   sum_signed_err
`endif
);

  state_e        state_q;
  logic [PW-1:0] cnt_q;
  logic          busy_q, done_q;
  logic          start_accept;
  logic          issue_valid;
  logic [PW-1:0] approx, exact;
  s1_t           s1_d, s1_q;

  assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign issue_valid  = (state_q == SWEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        SWEEP: begin
          if (cnt_q == SWEEP_LAST) begin
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        DRAIN: begin
          if (!issue_valid && !s1_q.valid) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  multiplier_8x8 u_mult (
    .A       (cnt_q[15:8]),
    .X       (cnt_q[7:0]),
    .product (approx)
  );

  assign exact = {8'd0, cnt_q[15:8]} * {8'd0, cnt_q[7:0]};

  always_comb begin
    s1_d        = s1_q;
    s1_d.a      = cnt_q[15:8];
    s1_d.x      = cnt_q[7:0];
    s1_d.approx = approx;
    s1_d.exact  = exact;
    s1_d.valid  = issue_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  err_accum u_accum (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (start_accept),
    .en_i             (s1_q.valid),
    .a_i              (s1_q.a),
    .x_i              (s1_q.x),
    .approx_i         (s1_q.approx),
    .exact_i          (s1_q.exact),
    .correct_cnt_o    (correct_cnt),
    .err_cnt_o        (err_cnt),
    .sum_abs_err_o    (sum_abs_err),
    .max_abs_err_o    (max_abs_err),
    .max_err_a_o      (max_err_a),
    .max_err_x_o      (max_err_x)
`ifdef SIGNED_BIAS_EN
    ,
    .sum_signed_err_o (sum_signed_err)
`endif
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/approx_mult_sweep_ctrl.md
Name: approx_mult_sweep_ctrl

Overview:
- Hardware error-characterisation controller for the 8x8 approximate multiplier (`multiplier_8x8`, combinational; ports A, X, product).
- On a start pulse it sequences operand pairs through one instance of that multiplier in a three-stage pipeline. Each approximate product is compared against an exact A*X.
- It accumulates correct count, error count, sum of absolute error and worst-case error with its operands.
- It is the on-chip counterpart of the exhaustive software sweep, for FPGA accuracy/power runs.

Parameters:
- SWEEP_LAST, 16'hFFFF, last flat pair index swept (index = {A,X}, X inner/LSB). Smaller values allow short sims.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- busy  out  1  high from the edge that accepts start until the sweep completes.
- done  out  1  level; high after completion until the next accepted start or reset.
- correct_cnt  out  17  pairs with approx == exact.
- err_cnt  out  17  pairs with approx != exact.
- sum_abs_err  out  32  sum over pairs of |exact - approx|.
- max_abs_err  out  16  largest |exact - approx|.
- max_err_a  out  8  A of the first pair reaching max_abs_err.
- max_err_x  out  8  X of the first pair reaching max_abs_err.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state IDLE, busy=0, done=0, every counter, accumulator and max register = 0, pipeline valids = 0.

State machine:
- IDLE: start -> SWEEP. Pair counter cnt<=0. Accumulators and max registers clear. done<=0, busy<=1.
- SWEEP: each cycle issues pair cnt (A=cnt[15:8], X=cnt[7:0]) with valid. On the cycle cnt==SWEEP_LAST: issue it, then -> DRAIN. cnt never wraps past SWEEP_LAST.
- DRAIN: wait until both pipeline valids are clear -> DONE. On the DONE entry edge: busy<=0, done<=1.
- DONE: results held stable. start -> same action as IDLE (restart, done drops on that edge).

Pipeline and timing:
- S0 is the combinational `multiplier_8x8` plus the exact product A*X (16 bits).
- S1 registers approx, exact, A, X and valid.
- S2 updates the accumulators from the S1 registers.
- Pair k is captured in S1 at edge k+1 after the start-sampling edge (edge 0), and accumulated at edge k+2.
- With N = SWEEP_LAST+1, done rises at edge N+2. Full sweep: 65538 cycles.

Arithmetic:
- abs_err = |exact - approx| computed at 17 bits and truncated to 16 bits (cannot exceed 65535).
- sum_abs_err is 32 bits. It cannot overflow: max 65536*65025 < 2^32.
- correct_cnt + err_cnt == N at done.
- Max update only on abs_err > max_abs_err (strictly greater). The first occurrence in sweep order wins ties. A max of 0 leaves max_err_a/x = 0.

Boundary conditions:
- start while busy: ignored, no restart.
- start in the same cycle as reset: reset wins.
- Reset mid-sweep: everything returns to reset values immediately (asynchronous). No partial results are retained.
- Outputs are live (partial) during busy. They are valid only when done=1.

Optional Feature:
- Macro: SIGNED_BIAS_EN.
- Defined: adds output port sum_signed_err, 33-bit two's complement, = sum over pairs of (approx - exact). It is cleared on start/reset and updated in S2 alongside sum_abs_err, giving the mean error bias.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package approx_sweep_pkg holds:
  - OPW=8, PW=16, CNTW=17, SUMW=32.
  - The state enum {IDLE, SWEEP, DRAIN, DONE}.
  - A struct for the S1 stage (a, x, approx, exact, valid).
- One natural sub-module: err_accum, i.e. S2. It holds the accumulators and max tracking, with a clear/enable interface. The FSM, counter and multiplier instance stay in the top.

Test Plan:
- Exact stub multiplier_8x8 (product = A*X), full sweep -> done at edge 65538. correct_cnt=65536, err_cnt=0, sum_abs_err=0, max_abs_err=0, max_err_a=0, max_err_x=0.
- Stub product = (A*X)^1, full sweep -> err_cnt=65536, correct_cnt=0, sum_abs_err=65536, max_abs_err=1, max_err_a=0, max_err_x=0 (first pair).
- Stub zeroing product only for A=255, X=255 -> err_cnt=1, sum_abs_err=65025, max_abs_err=65025, max_err_a=255, max_err_x=255.
- SWEEP_LAST=16'h0003 with the (A*X)^1 stub -> done rises at edge 6, err_cnt=4, correct_cnt=0. start pulsed at edge 2 is ignored. A second start in DONE reruns and gives identical results.
- Assert rst at edge 100 of a full sweep -> all outputs 0 immediately, busy=0, done=0. A later start completes normally.
- SIGNED_BIAS_EN with a stub product = A*X - 1 (saturating at 0) -> sum_signed_err = -(65536 - 511) = -65025, since the 511 pairs with exact product 0 (A=0 or X=0) have no error.
